decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have clock: clk, input, 1, all state updates on rising edge.
REQ-002 SHALL have reset: rst_n, input, 1, asynchronous, active-low.
REQ-003 SHALL have fetch inputs: f_icode 4, f_ifun 4, f_rA 4, f_rB 4, f_valC 64, f_valP 64, f_stat 3, all from fetch stage.
REQ-004 SHALL have pipeline controls: D_stall 1 (hold D register), D_bubble 1 (load nop into D), E_bubble 1 (load nop into E).
REQ-005 SHALL have write-back inputs: W_dstE 4, W_valE 64, W_dstM 4, W_valM 64; dst 4'hF means no write.
REQ-006 SHALL have registered outputs: E_icode 4, E_ifun 4, E_valC 64, E_valA 64, E_valB 64, E_srcA 4, E_srcB 4, E_dstE 4, E_dstM 4, E_stat 3.
REQ-007 SHALL have combinational outputs: d_srcA 4, d_srcB 4, for the hazard unit.

Function
REQ-008 D register SHALL capture all f_* inputs each edge unless D_stall=1 (hold) or D_bubble=1 (bubble); D_stall wins over D_bubble.
REQ-009 Bubble SHALL mean icode=NOP(1), ifun=0, rA=rB=F, valC=valP=0, stat=AOK; E bubble also sets srcA=srcB=dstE=dstM=F, valA=valB=0.
REQ-010 srcA SHALL be D_rA for RRMOVQ(2), RMMOVQ(4), OPQ(6), PUSHQ(A); RSP(4) for POPQ(B), RET(9); else F.
REQ-011 srcB SHALL be D_rB for OPQ, RMMOVQ, MRMOVQ(5); RSP for PUSHQ, POPQ, CALL(8), RET; else F.
REQ-012 dstE SHALL be D_rB for RRMOVQ, IRMOVQ(3), OPQ; RSP for PUSHQ, POPQ, CALL, RET; else F.
REQ-013 dstM SHALL be D_rA for MRMOVQ, POPQ; else F.
REQ-014 valA SHALL be D_valP for CALL and JXX(7); otherwise register-file read of srcA; valB SHALL be read of srcB.
REQ-015 Read of ID F SHALL return 0.
REQ-016 Register file SHALL hold 15 x 64-bit registers (IDs 0..14); writes on rising edge via port E and port M; write to ID F ignored.
REQ-017 Same-cycle write and read of same ID SHALL return the value being written (write-through bypass).
REQ-018 Ports E and M targeting same ID in one cycle: port M value SHALL be stored and bypassed.
REQ-019 E register SHALL load decoded D contents each edge unless E_bubble=1 (bubble); E never stalls.
REQ-020 Latency: f_* sampled at edge N SHALL appear on E_* after edge N+1 (no stalls/bubbles).
REQ-021 D stat other than AOK SHALL propagate unchanged to E_stat; decode fields still computed normally.
REQ-022 d_srcA/d_srcB SHALL equal the srcA/srcB of REQ-010/011 for current D contents.

Reset
REQ-023 rst_n low SHALL immediately force D and E registers to bubble values and all 15 registers to 0.
REQ-024 Reset mid-instruction SHALL discard all in-flight D/E contents; first capture occurs on first edge with rst_n high.
REQ-025 W_* writes SHALL be ignored while rst_n is low.

Structure
REQ-026 Shared package y86_pkg SHALL hold icode constants, RNONE=4'hF, RRSP=4'h4, stat codes AOK=1, HLT=2, ADR=3, INS=4.
REQ-027 Register file SHALL be a sub-module y86_regfile (2 read, 2 write ports, bypass, async reset).
REQ-028 Decode selection logic and D/E pipeline registers SHALL reside in decode_stage.

Verification
REQ-029 Reset, then f_icode=3, rB=2, valC=0x10 -> after 2 edges E_dstE=2, E_valC=0x10, E_srcA=E_srcB=F.
REQ-030 W_dstE=3, W_valE=0x55 same cycle as D holds OPQ rA=3,rB=3 -> E_valA=E_valB=0x55; next read of R3 also 0x55.
REQ-031 W_dstE=4, W_valE=0x100, W_dstM=4, W_valM=0x200 -> R4 reads 0x200.
REQ-032 D holds CALL, valP=0x40, RSP=0x80 -> E_valA=0x40, E_valB=0x80, E_dstE=4, E_dstM=F.
REQ-033 D_stall=1 and D_bubble=1 for 2 edges with changing f_* -> D contents held; E repeats same decode; E_bubble=1 -> E_icode=1, all dst F.
REQ-034 rst_n low mid-stream with R1=0x7 -> E outputs bubble immediately; R1 reads 0 after release.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline register layouts for the decode stage.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    localparam int NREGS = 15;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [2:0]  stat;
    } d_reg_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  stat;
    } e_reg_t;

    localparam d_reg_t D_BUBBLE = '{icode: INOP, ifun: 4'h0, rA: RNONE, rB: RNONE,
                                    valC: 64'h0, valP: 64'h0, stat: AOK};
    localparam e_reg_t E_BUBBLE = '{icode: INOP, ifun: 4'h0, valC: 64'h0, valA: 64'h0,
                                    valB: 64'h0, srcA: RNONE, srcB: RNONE,
                                    dstE: RNONE, dstM: RNONE, stat: AOK};
endpackage

// File: rtl/decode_stage_if.sv
// Fetch/control/write-back inputs and E-register/hazard outputs of the decode stage.
interface decode_stage_if;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [2:0]  f_stat;
    logic        D_stall, D_bubble, E_bubble;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [2:0]  E_stat;
    logic [3:0]  d_srcA, d_srcB;

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        output D_stall, D_bubble, E_bubble, W_dstE, W_valE, W_dstM, W_valM,
        input  E_icode, E_ifun, E_valC, E_valA, E_valB, E_srcA, E_srcB,
        input  E_dstE, E_dstM, E_stat, d_srcA, d_srcB
    );
    modport slave (
        input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
        input  D_stall, D_bubble, E_bubble, W_dstE, W_valE, W_dstM, W_valM,
        output E_icode, E_ifun, E_valC, E_valA, E_valB, E_srcA, E_srcB,
        output E_dstE, E_dstM, E_stat, d_srcA, d_srcB
    );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two read ports with write-through bypass, two write ports.
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o,
    input  logic [3:0]  dstE_i,
    input  logic [63:0] valE_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valM_i
);
    logic [63:0] regs_q [NREGS];

    // Port M is written last so it wins when both ports target one register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (dstE_i != RNONE) regs_q[dstE_i] <= valE_i;
            if (dstM_i != RNONE) regs_q[dstM_i] <= valM_i;
        end
    end

    function automatic logic [63:0] rd(input logic [3:0] id);
        if (id == RNONE)                  return '0;
        else if (rst_n && dstM_i == id)   return valM_i;
        else if (rst_n && dstE_i == id)   return valE_i;
        else                              return regs_q[id];
    endfunction

    always_comb begin
        valA_o = rd(srcA_i);
        valB_o = rd(srcB_i);
    end
endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, source/destination selection, E register.
module decode_stage
    import y86_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  dec_if
);
    d_reg_t      d_q, d_d;
    e_reg_t      e_q, e_d;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b;

    // Stall takes priority over bubble on the D register.
    always_comb begin
        d_d = '{icode: dec_if.f_icode, ifun: dec_if.f_ifun, rA: dec_if.f_rA, rB: dec_if.f_rB,
                valC: dec_if.f_valC, valP: dec_if.f_valP, stat: dec_if.f_stat};
        if (dec_if.D_stall)       d_d = d_q;
        else if (dec_if.D_bubble) d_d = D_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= D_BUBBLE;
        else        d_q <= d_d;
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d_q.icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = d_q.rA;
            IPOPQ, IRET:                    src_a = RRSP;
            default: ;
        endcase
        case (d_q.icode)
            IOPQ, IRMMOVQ, IMRMOVQ:         src_b = d_q.rB;
            IPUSHQ, IPOPQ, ICALL, IRET:     src_b = RRSP;
            default: ;
        endcase
        case (d_q.icode)
            IRRMOVQ, IIRMOVQ, IOPQ:         dst_e = d_q.rB;
            IPUSHQ, IPOPQ, ICALL, IRET:     dst_e = RRSP;
            default: ;
        endcase
        case (d_q.icode)
            IMRMOVQ, IPOPQ:                 dst_m = d_q.rA;
            default: ;
        endcase
    end

    y86_regfile u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .srcA_i (src_a),
        .srcB_i (src_b),
        .valA_o (rf_a),
        .valB_o (rf_b),
        .dstE_i (dec_if.W_dstE),
        .valE_i (dec_if.W_valE),
        .dstM_i (dec_if.W_dstM),
        .valM_i (dec_if.W_valM)
    );

    // CALL and JXX carry valP down the valA lane instead of a register read.
    always_comb begin
        e_d = '{icode: d_q.icode, ifun: d_q.ifun, valC: d_q.valC,
                valA: (d_q.icode == ICALL || d_q.icode == IJXX) ? d_q.valP : rf_a,
                valB: rf_b, srcA: src_a, srcB: src_b, dstE: dst_e, dstM: dst_m,
                stat: d_q.stat};
        if (dec_if.E_bubble) e_d = E_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= E_BUBBLE;
        else        e_q <= e_d;
    end

    assign dec_if.E_icode = e_q.icode;
    assign dec_if.E_ifun  = e_q.ifun;
    assign dec_if.E_valC  = e_q.valC;
    assign dec_if.E_valA  = e_q.valA;
    assign dec_if.E_valB  = e_q.valB;
    assign dec_if.E_srcA  = e_q.srcA;
    assign dec_if.E_srcB  = e_q.srcB;
    assign dec_if.E_dstE  = e_q.dstE;
    assign dec_if.E_dstM  = e_q.dstM;
    assign dec_if.E_stat  = e_q.stat;
    assign dec_if.d_srcA  = src_a;
    assign dec_if.d_srcB  = src_b;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic vs a cycle model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if dif ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .dec_if(dif));

    typedef struct packed {
        logic [3:0] icode, ifun, rA, rB; logic [63:0] valC, valP; logic [2:0] stat;
    } md_t;
    typedef struct packed {
        logic [3:0] icode, ifun; logic [63:0] valC, valA, valB;
        logic [3:0] srcA, srcB, dstE, dstM; logic [2:0] stat;
    } me_t;

    localparam md_t MD_NOP = '{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1};
    localparam me_t ME_NOP = '{4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 3'd1};

    md_t         md;
    me_t         me;
    logic [63:0] mregs [16];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [3:0] m_srcA(md_t d);
        if (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return d.rA;
        if (d.icode inside {4'hB, 4'h9})             return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] m_srcB(md_t d);
        if (d.icode inside {4'h6, 4'h4, 4'h5})       return d.rB;
        if (d.icode inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] m_dstE(md_t d);
        if (d.icode inside {4'h2, 4'h3, 4'h6})       return d.rB;
        if (d.icode inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] m_dstM(md_t d);
        return (d.icode inside {4'h5, 4'hB}) ? d.rA : 4'hF;
    endfunction
    // A read sees this cycle's write-back; port M beats port E.
    function automatic logic [63:0] m_rd(logic [3:0] id);
        if (id == 4'hF)        return 64'h0;
        if (dif.W_dstM == id)  return dif.W_valM;
        if (dif.W_dstE == id)  return dif.W_valE;
        return mregs[id];
    endfunction
    function automatic me_t dut_e();
        return '{dif.E_icode, dif.E_ifun, dif.E_valC, dif.E_valA, dif.E_valB,
                 dif.E_srcA, dif.E_srcB, dif.E_dstE, dif.E_dstM, dif.E_stat};
    endfunction

    task automatic set_f(logic [3:0] ic, logic [3:0] ra, logic [3:0] rb,
                         logic [63:0] vc, logic [63:0] vp, logic [2:0] st);
        dif.f_icode = ic; dif.f_ifun = 4'h0; dif.f_rA = ra; dif.f_rB = rb;
        dif.f_valC = vc; dif.f_valP = vp; dif.f_stat = st;
    endtask
    task automatic set_w(logic [3:0] de, logic [63:0] ve, logic [3:0] dm, logic [63:0] vm);
        dif.W_dstE = de; dif.W_valE = ve; dif.W_dstM = dm; dif.W_valM = vm;
    endtask
    task automatic set_ctl(logic ds, logic db, logic eb);
        dif.D_stall = ds; dif.D_bubble = db; dif.E_bubble = eb;
    endtask

    // Advance DUT and model one clock; inputs must be stable before the call.
    task automatic tick();
        md_t dn;
        me_t en;
        if (dif.E_bubble) en = ME_NOP;
        else begin
            en.icode = md.icode; en.ifun = md.ifun; en.valC = md.valC; en.stat = md.stat;
            en.srcA = m_srcA(md); en.srcB = m_srcB(md);
            en.dstE = m_dstE(md); en.dstM = m_dstM(md);
            en.valA = (md.icode == 4'h8 || md.icode == 4'h7) ? md.valP : m_rd(en.srcA);
            en.valB = m_rd(en.srcB);
        end
        if (dif.D_stall)       dn = md;
        else if (dif.D_bubble) dn = MD_NOP;
        else dn = '{dif.f_icode, dif.f_ifun, dif.f_rA, dif.f_rB, dif.f_valC, dif.f_valP, dif.f_stat};
        if (dif.W_dstE != 4'hF) mregs[dif.W_dstE] = dif.W_valE;
        if (dif.W_dstM != 4'hF) mregs[dif.W_dstM] = dif.W_valM;
        @(posedge clk);
        md = dn;
        me = en;
        #1;
    endtask

    task automatic model_reset();
        md = MD_NOP;
        me = ME_NOP;
        for (int i = 0; i < 16; i++) mregs[i] = 64'h0;
    endtask

    task automatic test_reset();
        set_ctl(0, 0, 0);
        set_w(4'h2, 64'hdead, 4'h3, 64'hbeef);
        set_f(4'h6, 4'h2, 4'h3, 64'h1, 64'h2, 3'd1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dut_e() !== ME_NOP) begin
            fails++; $display("FAIL reset_E act=%h exp=%h", dut_e(), ME_NOP);
        end
        tests++;
        if (dif.d_srcA !== 4'hF || dif.d_srcB !== 4'hF) begin
            fails++; $display("FAIL reset_dsrc act=%h/%h exp=f/f", dif.d_srcA, dif.d_srcB);
        end
        set_w(4'hF, 0, 4'hF, 0);
        set_f(4'h1, 4'hF, 4'hF, 0, 0, 3'd1);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_irmovq();
        set_f(4'h3, 4'hF, 4'h2, 64'h10, 64'h0, 3'd1);
        tick();
        set_f(4'h1, 4'hF, 4'hF, 0, 0, 3'd1);
        tick();
        tests++;
        if (dif.E_dstE !== 4'h2 || dif.E_valC !== 64'h10 || dif.E_srcA !== 4'hF || dif.E_srcB !== 4'hF) begin
            fails++;
            $display("FAIL irmovq act dstE=%h valC=%h srcA=%h srcB=%h exp 2/10/f/f",
                     dif.E_dstE, dif.E_valC, dif.E_srcA, dif.E_srcB);
        end
    endtask

    task automatic test_bypass();
        set_f(4'h6, 4'h3, 4'h3, 0, 0, 3'd1);
        tick();
        set_w(4'h3, 64'h55, 4'hF, 0);
        tick();
        tests++;
        if (dif.E_valA !== 64'h55 || dif.E_valB !== 64'h55) begin
            fails++; $display("FAIL bypass act=%h/%h exp=55/55", dif.E_valA, dif.E_valB);
        end
        set_w(4'hF, 0, 4'hF, 0);
        tick();
        tests++;
        if (dif.E_valA !== 64'h55) begin
            fails++; $display("FAIL bypass_stored act=%h exp=55", dif.E_valA);
        end
    endtask

    task automatic test_same_dst();
        set_f(4'h2, 4'h4, 4'h5, 0, 0, 3'd1);
        tick();
        set_w(4'h4, 64'h100, 4'h4, 64'h200);
        tick();
        tests++;
        if (dif.E_valA !== 64'h200) begin
            fails++; $display("FAIL same_dst_bypass act=%h exp=200", dif.E_valA);
        end
        set_w(4'hF, 0, 4'hF, 0);
        tick();
        tests++;
        if (dif.E_valA !== 64'h200) begin
            fails++; $display("FAIL same_dst_stored act=%h exp=200", dif.E_valA);
        end
    endtask

    task automatic test_call();
        set_w(4'h4, 64'h80, 4'hF, 0);
        set_f(4'h8, 4'hF, 4'hF, 64'h1234, 64'h40, 3'd1);
        tick();
        set_w(4'hF, 0, 4'hF, 0);
        set_f(4'h1, 4'hF, 4'hF, 0, 0, 3'd1);
        tick();
        tests++;
        if (dif.E_valA !== 64'h40 || dif.E_valB !== 64'h80 || dif.E_dstE !== 4'h4 || dif.E_dstM !== 4'hF) begin
            fails++;
            $display("FAIL call act valA=%h valB=%h dstE=%h dstM=%h exp 40/80/4/f",
                     dif.E_valA, dif.E_valB, dif.E_dstE, dif.E_dstM);
        end
    endtask

    task automatic test_stall_bubble();
        set_f(4'h6, 4'h1, 4'h2, 64'h0, 64'h0, 3'd1);
        tick();
        set_ctl(1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            set_f(4'($urandom_range(0, 11)), 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'd2);
            tick();
            tests++;
            if (dif.E_icode !== 4'h6 || dif.E_srcA !== 4'h1 || dif.E_srcB !== 4'h2 || dif.E_dstE !== 4'h2 || dut_e() !== me) begin
                fails++; $display("FAIL stall_hold[%0d] act=%h exp=%h", i, dut_e(), me);
            end
        end
        set_ctl(0, 0, 1);
        tick();
        tests++;
        if (dif.E_icode !== 4'h1 || dif.E_dstE !== 4'hF || dif.E_dstM !== 4'hF || dif.E_srcA !== 4'hF) begin
            fails++; $display("FAIL e_bubble act=%h exp icode=1 dst=f", dut_e());
        end
        set_ctl(0, 0, 0);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            set_f(4'($urandom_range(0, 11)), 4'($urandom), 4'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(1, 4)));
            dif.f_ifun = 4'($urandom);
            set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            set_w(($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom), {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom), {$urandom, $urandom});
            tick();
            tests++;
            if (dut_e() !== me || dif.d_srcA !== m_srcA(md) || dif.d_srcB !== m_srcB(md)) begin
                fails++;
                if (bad++ < 5)
                    $display("FAIL random[%0d] act=%h dsrc=%h%h exp=%h dsrc=%h%h",
                             c, dut_e(), dif.d_srcA, dif.d_srcB, me, m_srcA(md), m_srcB(md));
            end
        end
        set_ctl(0, 0, 0);
        set_w(4'hF, 0, 4'hF, 0);
    endtask

    task automatic test_reset_mid();
        set_w(4'h1, 64'h7, 4'hF, 0);
        set_f(4'h6, 4'h1, 4'h1, 64'h9, 64'h9, 3'd1);
        tick();
        set_w(4'hF, 0, 4'hF, 0);
        tick();
        tests++;
        if (dif.E_valA !== 64'h7) begin
            fails++; $display("FAIL pre_reset_r1 act=%h exp=7", dif.E_valA);
        end
        #2 rst_n = 1'b0;
        set_w(4'h1, 64'h99, 4'h1, 64'h77);
        model_reset();
        #1;
        tests++;
        if (dut_e() !== ME_NOP) begin
            fails++; $display("FAIL reset_mid_E act=%h exp=%h", dut_e(), ME_NOP);
        end
        @(posedge clk);
        #3;
        set_w(4'hF, 0, 4'hF, 0);
        set_f(4'h2, 4'h1, 4'h3, 0, 0, 3'd1);
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if (dif.E_valA !== 64'h0 || dif.E_icode !== 4'h2 || dut_e() !== me) begin
            fails++; $display("FAIL reset_mid_r1 act=%h valA=%h exp valA=0 icode=2", dut_e(), dif.E_valA);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq();
        test_bypass();
        test_same_dst();
        test_call();
        test_stall_bubble();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
